// File: rtl/dmem_port_arbiter.sv
// Two-master round-robin arbiter for a single-port data memory, with a
// bounded lock so one master can keep the port for back-to-back accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OWN_NONE | port free; round-robin between m0 and m1 using pri_q
// OWN_M0   | m0 holds the port; only m0 may be granted
// OWN_M1   | m1 holds the port; only m1 may be granted
module dmem_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pri_q, pri_d;
  logic             lock_g;

  // Ownership, lock count and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
    end
  end

  // Grant decision and next ownership; grants are masked while in reset so
  // an access cannot reach the memory during the reset window
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    cnt_inc = cnt_q + 1'b1;

    if (rst_n) begin
      unique case (owner_q)
        OWN_NONE: begin
          if (m0_req && (!m1_req || !pri_q)) m0_gnt = 1'b1;
          else if (m1_req)                   m1_gnt = 1'b1;
        end
        OWN_M0:  m0_gnt = m0_req;
        OWN_M1:  m1_gnt = m1_req;
        default: ;
      endcase
    end

    lock_g = m0_gnt ? m0_lock : m1_lock;

    if (m0_gnt || m1_gnt) begin
      // Reaching MAX_LOCK on this grant forces release, so MAX_LOCK=1 never locks
      if (lock_g && (cnt_inc < CNT_MAX)) begin
        owner_d = m0_gnt ? OWN_M0 : OWN_M1;
        cnt_d   = cnt_inc;
      end else begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        pri_d   = m0_gnt;
      end
    end
  end

  // Memory port mux; idle drives all zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Read return: capture memory data on a granted read, one-cycle rvalid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a behavioural 64x32 memory, per-cycle grant
// expectations, and per-master queues of expected read data.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [5:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] last0, last1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  dmem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check grant/memory drive, then check
  // the read return after the following rising edge.
  task automatic step(input logic r0, input logic w0, input logic l0,
                      input logic [5:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [5:0] a1, input logic [31:0] d1,
                      input logic e0, input logic e1);
    logic        xwe, wr;
    logic [5:0]  xa, wa;
    logic [31:0] xd, wd;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    xwe = e0 ? w0 : (e1 ? w1 : 1'b0);
    xa  = e0 ? a0 : (e1 ? a1 : 6'd0);
    xd  = e0 ? (w0 ? d0 : m0_wdata) : (e1 ? m1_wdata : 32'd0);
    chk("mem_we", 32'(mem_we), 32'(xwe));
    chk("mem_addr", 32'(mem_addr), 32'(xa));
    chk("mem_wdata", mem_wdata, xd);
    if (e0 && !w0) q0.push_back(ref_mem[a0]);
    if (e0 && w0)  ref_mem[a0] = d0;
    if (e1 && !w1) q1.push_back(ref_mem[a1]);
    if (e1 && w1)  ref_mem[a1] = d1;
    #3;
    wr = mem_we; wa = mem_addr; wd = mem_wdata;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e0 && !w0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e1 && !w1));
    if (m0_rvalid && q0.size() > 0) last0 = q0.pop_front();
    if (m1_rvalid && q1.size() > 0) last1 = q1.pop_front();
    chk("m0_rdata", m0_rdata, last0);
    chk("m1_rdata", m1_rdata, last1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 + 32'(i);
      ref_mem[i] = 32'hA000_0000 + 32'(i);
    end
    mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    last0 = '0; last1 = '0;

    // reset holds grants and write enable low even with requests present
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 6'd1; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 6'd2; m1_wdata = 32'h2;
    #12;
    chk("rst_m0_gnt", 32'(m0_gnt), 0);
    chk("rst_m1_gnt", 32'(m1_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;

    // single read of preloaded word
    step(1,0,0,6'd5,0,        0,0,0,6'd0,0,        1,0);
    // m1 alone, leaves pri pointing at m0
    step(0,0,0,6'd0,0,        1,0,0,6'd7,0,        0,1);
    // contention, unlocked: alternate starting with m0; read-after-write on addr 3
    step(1,1,0,6'd3,32'h11,   1,0,0,6'd3,0,        1,0);
    step(1,0,0,6'd4,0,        1,0,0,6'd3,0,        0,1);
    step(1,0,0,6'd4,0,        1,0,0,6'd9,0,        1,0);
    step(1,0,0,6'd10,0,       1,0,0,6'd9,0,        0,1);
    // m1 locks for three accesses while m0 keeps requesting
    step(1,0,0,6'd11,0,       1,0,1,6'd20,0,       1,0);
    step(1,0,0,6'd12,0,       1,0,1,6'd20,0,       0,1);
    step(1,0,0,6'd12,0,       1,1,1,6'd21,32'h55,  0,1);
    step(1,0,0,6'd12,0,       1,0,0,6'd21,0,       0,1);
    step(1,0,0,6'd12,0,       0,0,0,6'd0,0,        1,0);
    // point pri back at m0
    step(0,0,0,6'd0,0,        1,0,0,6'd30,0,       0,1);
    // m0 holds lock forever: exactly MAX_LOCK grants, then m1, then m0
    for (int i = 0; i < 8; i++)
      step(1,0,1,6'(i),0,     1,0,0,6'd30,0,       1,0);
    step(1,0,1,6'd8,0,        1,0,0,6'd30,0,       0,1);
    step(1,0,1,6'd9,0,        1,0,0,6'd31,0,       1,0);
    // locked owner idles two cycles: nothing granted, m1 write blocked
    repeat (2)
      step(0,0,1,6'd0,0,      1,1,0,6'd31,32'hBAD, 0,0);
    // lock count resumes from one: seven more grants before release
    for (int i = 0; i < 7; i++)
      step(1,0,1,6'(16+i),0,  1,1,0,6'd31,32'hBAD, 1,0);
    step(1,0,1,6'd23,0,       1,1,0,6'd31,32'hBAD, 0,1);
    // m0 read leaves pri pointing at m1
    step(1,0,0,6'd31,0,       0,0,0,6'd0,0,        1,0);

    // reset lands in the middle of a granted m1 read
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 6'd5;
    #1;
    chk("pre_rst_m1_gnt", 32'(m1_gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m1_gnt", 32'(m1_gnt), 0);
    chk("mid_rst_m0_gnt", 32'(m0_gnt), 0);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    chk("mid_rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("mid_rst_m1_rdata", m1_rdata, 0);
    chk("mid_rst_m0_rdata", m0_rdata, 0);
    last0 = '0; last1 = '0;
    @(negedge clk);
    m1_req = 1'b0;
    rst_n = 1'b1;
    // pri was pointing at m1 before reset; after reset m0 must win
    step(1,0,0,6'd5,0,        1,0,0,6'd6,0,        1,0);
    step(0,0,0,6'd0,0,        1,0,0,6'd6,0,        0,1);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
